// File: rtl/register_file.sv
// Multi-port register file with a zeroing sweep after reset and per-register busy tracking.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy) to matching read ports.
module register_file #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [AW-1:0]         writeReg,
    input  logic [XLEN-1:0]       writeData,
    input  logic [NREAD*AW-1:0]   readRegs,
    output logic [NREAD*XLEN-1:0] readData,
    input  logic                  setBusy,
    input  logic [AW-1:0]         busyReg,
    output logic [NREAD-1:0]      readBusy,
    output logic                  ready,
    output logic                  o_dbg_state
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_init_cnt;
    logic [AW-1:0]   w_next_cnt;
    logic            r_ready;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic w_run;
    logic w_wr_en;
    logic w_set_en;

    assign w_run    = (r_state == ST_RUN);
    assign w_wr_en  = w_run && RegWrite && (writeReg != '0);
    assign w_set_en = w_run && setBusy && (busyReg != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_init_cnt <= w_next_cnt;
            r_ready    <= (w_next_state == ST_RUN);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_init_cnt;
        case (r_state)
            ST_INIT: begin
                w_next_cnt = r_init_cnt + 1'b1;
                if (r_init_cnt == AW'(NREGS - 1)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // Contents are zeroed only by the sweep; reset merely stalls updates.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_regs[r_init_cnt] <= '0;
            end else if (w_wr_en) begin
                r_regs[writeReg] <= writeData;
            end
        end
    end

    // Set is applied after clear so a same-register producer keeps the flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[writeReg] <= 1'b0;
            end
            if (w_set_en) begin
                r_busy[busyReg] <= 1'b1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp_busy;
    assign w_byp_busy = w_set_en && (busyReg == writeReg);
`endif

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0] w_addr;
        logic          w_valid;
        assign w_addr  = readRegs[p*AW +: AW];
        assign w_valid = w_run && (w_addr != '0);
`ifdef REGFILE_BYPASS_EN
        logic w_byp;
        assign w_byp = w_wr_en && (w_addr == writeReg);
        assign readData[p*XLEN +: XLEN] = !w_valid ? '0
                                        : w_byp  ? writeData
                                        : r_regs[w_addr];
        assign readBusy[p] = !w_valid ? 1'b0
                           : w_byp  ? w_byp_busy
                           : r_busy[w_addr];
`else
        assign readData[p*XLEN +: XLEN] = w_valid ? r_regs[w_addr] : '0;
        assign readBusy[p]              = w_valid ? r_busy[w_addr] : 1'b0;
`endif
    end

    assign ready       = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: default instance (32x32, 2 ports) and a 16-entry, 4-port instance.
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic        clock;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [9:0]  readRegs;
    logic [63:0] readData;
    logic        setBusy;
    logic [4:0]  busyReg;
    logic [1:0]  readBusy;
    logic        ready;
    logic        dbg_a;

    logic         reset_b;
    logic         RegWrite_b;
    logic [3:0]   writeReg_b;
    logic [31:0]  writeData_b;
    logic [15:0]  readRegs_b;
    logic [127:0] readData_b;
    logic         setBusy_b;
    logic [3:0]   busyReg_b;
    logic [3:0]   readBusy_b;
    logic         ready_b;
    logic         dbg_b;

    register_file u_dut (
        .clock(clock), .reset(reset), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .readRegs(readRegs), .readData(readData),
        .setBusy(setBusy), .busyReg(busyReg), .readBusy(readBusy),
        .ready(ready), .o_dbg_state(dbg_a)
    );

    register_file #(.XLEN(32), .NREGS(16), .NREAD(4)) u_dut_b (
        .clock(clock), .reset(reset_b), .RegWrite(RegWrite_b), .writeReg(writeReg_b),
        .writeData(writeData_b), .readRegs(readRegs_b), .readData(readData_b),
        .setBusy(setBusy_b), .busyReg(busyReg_b), .readBusy(readBusy_b),
        .ready(ready_b), .o_dbg_state(dbg_b)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_a(input int p);
        return readData[p*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_b(input int p);
        return readData_b[p*32 +: 32];
    endfunction

    task automatic idle_a();
        RegWrite = 1'b0; writeReg = '0; writeData = '0;
        setBusy  = 1'b0; busyReg  = '0;
    endtask

    initial begin
        idle_a();
        readRegs = '0;
        reset    = 1'b1;
        reset_b  = 1'b1;
        RegWrite_b = 1'b0; writeReg_b = '0; writeData_b = '0;
        setBusy_b  = 1'b0; busyReg_b  = '0; readRegs_b  = '0;

        // Reset edge, then the 32-cycle sweep
        tick();
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_data0", rd_a(0), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            idle_a();
            if (k >= 20 && k <= 31) begin
                RegWrite = 1'b1; writeReg = 5'd9; writeData = 32'hFFFF_FFFF;
                setBusy  = 1'b1; busyReg  = 5'd9;
            end
            readRegs = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            #1;
            chk("sweep_ready", 32'(ready), (k == 32) ? 32'd1 : 32'd0);
            chk("sweep_rd0", rd_a(0), 32'd0);
            chk("sweep_rd1", rd_a(1), 32'd0);
            chk("sweep_busy", 32'(readBusy), 32'd0);
        end
        readRegs = {5'd0, 5'd9};
        #1;
        chk("init_wr_ignored", rd_a(0), 32'd0);
        chk("init_busy_ignored", 32'(readBusy[0]), 32'd0);

        // Write x5, then attempt x0
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
        readRegs = {5'd0, 5'd5};
        #1;
        chk("x5_same_cycle", rd_a(0), BYP ? 32'hDEAD_BEEF : 32'd0);
        tick();
        writeReg = 5'd0; writeData = 32'h1234_5678;
        #1;
        chk("x5_after", rd_a(0), 32'hDEAD_BEEF);
        chk("x0_same_cycle", rd_a(1), 32'd0);
        tick();
        idle_a();
        readRegs = {5'd5, 5'd0};
        #1;
        chk("x0_after", rd_a(0), 32'd0);
        chk("x5_port1", rd_a(1), 32'hDEAD_BEEF);
        readRegs = {5'd5, 5'd5};
        #1;
        chk("same_reg_p0", rd_a(0), 32'hDEAD_BEEF);
        chk("same_reg_p1", rd_a(1), 32'hDEAD_BEEF);

        // Busy tracking on x7
        setBusy = 1'b1; busyReg = 5'd7;
        readRegs = {5'd0, 5'd7};
        #1;
        chk("busy7_pre", 32'(readBusy[0]), 32'd0);
        tick();
        RegWrite = 1'b1; writeReg = 5'd7; writeData = 32'h1;
        #1;
        chk("busy7_set", 32'(readBusy[0]), 32'd1);
        chk("busy7_x0", 32'(readBusy[1]), 32'd0);
        chk("x7_wr1_same", rd_a(0), BYP ? 32'h1 : 32'h0);
        tick();
        setBusy = 1'b0; writeData = 32'h2;
        #1;
        chk("busy7_kept", 32'(readBusy[0]), BYP ? 32'd0 : 32'd1);
        chk("x7_wr2_same", rd_a(0), BYP ? 32'h2 : 32'h1);
        tick();
        idle_a();
        #1;
        chk("busy7_clear", 32'(readBusy[0]), 32'd0);
        chk("x7_data", rd_a(0), 32'h2);

        // Repeated set stays busy; write to non-busy stays non-busy
        setBusy = 1'b1; busyReg = 5'd8;
        readRegs = {5'd8, 5'd8};
        tick();
        tick();
        idle_a();
        #1;
        chk("busy8_p0", 32'(readBusy[0]), 32'd1);
        chk("busy8_p1", 32'(readBusy[1]), 32'd1);
        RegWrite = 1'b1; writeReg = 5'd5; writeData = 32'h11;
        readRegs = {5'd8, 5'd5};
        tick();
        idle_a();
        #1;
        chk("x5_nonbusy", 32'(readBusy[0]), 32'd0);
        chk("x8_still_busy", 32'(readBusy[1]), 32'd1);
        chk("x5_rewrite", rd_a(0), 32'h11);
        setBusy = 1'b1; busyReg = 5'd0;
        readRegs = {5'd0, 5'd0};
        tick();
        idle_a();
        #1;
        chk("x0_never_busy", 32'(readBusy), 32'd0);

        // Same-cycle read of x3 during its write
        RegWrite = 1'b1; writeReg = 5'd3; writeData = 32'hA5A5_A5A5;
        readRegs = {5'd0, 5'd3};
        #1;
        chk("x3_same_cycle", rd_a(0), BYP ? 32'hA5A5_A5A5 : 32'd0);
        tick();
        idle_a();
        #1;
        chk("x3_next_cycle", rd_a(0), 32'hA5A5_A5A5);

        // Instance B: reset mid-sweep, then full 16-cycle sweep
        reset_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            #1;
            chk("b_sweep1_ready", 32'(ready_b), 32'd0);
        end
        reset_b = 1'b1;
        tick();
        #1;
        chk("b_rst_ready", 32'(ready_b), 32'd0);
        reset_b = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            RegWrite_b = 1'b0; setBusy_b = 1'b0;
            if (k >= 10 && k <= 15) begin
                RegWrite_b = 1'b1; writeReg_b = 4'd3; writeData_b = 32'hFFFF_FFFF;
                setBusy_b  = 1'b1; busyReg_b  = 4'd3;
            end
            #1;
            chk("b_sweep2_ready", 32'(ready_b), (k == 16) ? 32'd1 : 32'd0);
        end
        readRegs_b = {4'd0, 4'd2, 4'd3, 4'd3};
        #1;
        chk("b_x3_p0", rd_b(0), 32'd0);
        chk("b_x3_p1", rd_b(1), 32'd0);
        chk("b_x2_p2", rd_b(2), 32'd0);
        chk("b_x0_p3", rd_b(3), 32'd0);
        chk("b_busy", 32'(readBusy_b), 32'd0);
        RegWrite_b = 1'b1; writeReg_b = 4'd3; writeData_b = 32'hCAFE_F00D;
        readRegs_b = {4'd3, 4'd3, 4'd3, 4'd3};
        tick();
        RegWrite_b = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            chk("b_x3_all_ports", rd_b(p), 32'hCAFE_F00D);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports (>=1).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-006 SHALL have port RegWrite  input  1  write enable.
REQ-007 SHALL have port writeReg  input  AW  write address.
REQ-008 SHALL have port writeData  input  XLEN  write data.
REQ-009 SHALL have port readRegs  input  NREAD*AW  read addresses, port p at bits [p*AW +: AW].
REQ-010 SHALL have port readData  output  NREAD*XLEN  read data, port p at bits [p*XLEN +: XLEN].
REQ-011 SHALL have port setBusy  input  1  marks a register as awaiting a pending write.
REQ-012 SHALL have port busyReg  input  AW  register to mark busy.
REQ-013 SHALL have port readBusy  output  NREAD  busy flag of each read port's addressed register.
REQ-014 SHALL have port ready  output  1  high when the initialisation sweep is complete.

Function
REQ-015 SHALL implement a two-state FSM: INIT (sweep) and RUN.
REQ-016 In INIT, SHALL write zero to register[initCnt] each cycle, incrementing initCnt from 0; after writing NREGS-1, SHALL enter RUN on the next edge (INIT lasts exactly NREGS cycles).
REQ-017 ready SHALL be 0 in INIT and 1 in RUN; it is a registered output.
REQ-018 In INIT, RegWrite and setBusy SHALL be ignored, and all readData SHALL be 0 and all readBusy 0.
REQ-019 In RUN, when RegWrite=1 and writeReg!=0, register[writeReg] SHALL take writeData on the rising edge.
REQ-020 Writes to register 0 SHALL be discarded; reads of register 0 SHALL return 0 and readBusy 0 in all states.
REQ-021 Reads SHALL be combinational: readData port p = register[readRegs port p], zero latency.
REQ-022 Multiple read ports addressing the same register SHALL all return the same value.
REQ-023 In RUN, setBusy=1 with busyReg!=0 SHALL set busy[busyReg] on the edge.
REQ-024 A RUN-state write with writeReg!=0 SHALL clear busy[writeReg] on the same edge.
REQ-025 Simultaneous setBusy and RegWrite to the same register: the data write SHALL occur and busy SHALL end set (new producer wins).
REQ-026 setBusy to an already-busy register SHALL leave it busy; RegWrite to a non-busy register SHALL leave it non-busy.
REQ-027 readBusy port p SHALL be the combinational value of busy[readRegs port p].

Reset
REQ-028 reset=1 at an edge SHALL enter INIT with initCnt=0, clear all busy bits, drive ready=0; takes priority over all other inputs.
REQ-029 reset asserted mid-INIT SHALL restart the sweep from register 0; reset held high SHALL hold initCnt at 0.
REQ-030 Register contents are not reset directly; they SHALL be zeroed only by the sweep.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN: when defined, in RUN with RegWrite=1 and writeReg!=0, any read port addressing writeReg SHALL return writeData combinationally and readBusy 0 for that port, unless setBusy targets the same register in that cycle, in which case readBusy SHALL be 1.
REQ-032 Without REGFILE_BYPASS_EN, same-cycle reads SHALL return the pre-write value and pre-write busy state; the new value appears the cycle after the edge.

Verification
REQ-033 Defaults; reset 1 cycle then release -> ready=0 for 32 cycles, ready=1 on the 33rd; all reads return 0x00000000 throughout.
REQ-034 RUN; write x5=0xDEADBEEF, then write x0=0x12345678 -> port0 reading x5 returns 0xDEADBEEF and port1 reading x0 returns 0.
REQ-035 RUN; setBusy x7 -> readBusy=1 for x7; next cycle write x7=0x1 with setBusy x7 -> busy stays 1; then write x7=0x2 alone -> busy 0 and data 0x2.
REQ-036 RUN; RegWrite x3=0xA5A5A5A5 while port0 reads x3 -> with REGFILE_BYPASS_EN same-cycle readData=0xA5A5A5A5; without it, old value that cycle and 0xA5A5A5A5 next cycle.
REQ-037 NREAD=4, NREGS=16; reset asserted at sweep cycle 7 -> ready rises exactly 16 cycles after reset release; RegWrite during INIT leaves target at 0.
